// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate, bounce, fill and count patterns advanced by a
// free-running tick or by manual stepping while paused.
module led_pattern_gen #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DIV   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             pause,
  input  logic             step,
  output logic [WIDTH-1:0] pattern,
  output logic             advance
);

  localparam logic [1:0] MODE_ROTATE = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_FILL   = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic [DIV-1:0]   DIV_MAX  = '1;
  localparam logic [WIDTH-1:0] SEED_ONE = WIDTH'(1);

  typedef enum logic {
    BNC_UP = 1'b0,
    BNC_DN = 1'b1
  } bnc_dir_e;

  logic [DIV-1:0]   div_q;
  logic             step_q;
  logic [1:0]       mode_q;
  bnc_dir_e         bnc_q;

  logic             tick_c;
  logic             step_rise_c;
  logic             adv_evt_c;
  logic             mode_chg_c;
  logic             one_hot_c;
  logic [WIDTH-1:0] pat_nxt_c;
  bnc_dir_e         bnc_nxt_c;

  // Event qualification: divider tick, or a step edge only while paused
  always_comb begin
    tick_c      = !pause && (div_q == DIV_MAX);
    step_rise_c = step && !step_q;
    adv_evt_c   = tick_c || (pause && step_rise_c);
    mode_chg_c  = (mode != mode_q);
    one_hot_c   = (pattern != '0) && ((pattern & (pattern - WIDTH'(1))) == '0);
  end

  // Next pattern; a mode change loads the seed and swallows any coincident event
  always_comb begin
    pat_nxt_c = pattern;
    bnc_nxt_c = bnc_q;
    if (mode_chg_c) begin
      bnc_nxt_c = BNC_UP;
      case (mode)
        MODE_ROTATE: pat_nxt_c = SEED_ONE;
        MODE_BOUNCE: pat_nxt_c = SEED_ONE;
        MODE_FILL:   pat_nxt_c = '0;
        MODE_COUNT:  pat_nxt_c = '0;
      endcase
    end else if (adv_evt_c) begin
      case (mode)
        MODE_ROTATE: begin
          if (pattern == '0)
            pat_nxt_c = SEED_ONE;
          else if (dir)
            pat_nxt_c = {pattern[0], pattern[WIDTH-1:1]};
          else
            pat_nxt_c = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
        end
        MODE_BOUNCE: begin
          if (!one_hot_c) begin
            pat_nxt_c = SEED_ONE;
            bnc_nxt_c = BNC_UP;
          end else if (bnc_q == BNC_UP) begin
            if (pattern[WIDTH-1]) begin
              pat_nxt_c = pattern >> 1;
              bnc_nxt_c = BNC_DN;
            end else begin
              pat_nxt_c = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              pat_nxt_c = pattern << 1;
              bnc_nxt_c = BNC_UP;
            end else begin
              pat_nxt_c = pattern >> 1;
            end
          end
        end
        MODE_FILL: begin
          if (pattern == '1)
            pat_nxt_c = '0;
          else if (dir)
            pat_nxt_c = {1'b1, pattern[WIDTH-1:1]};
          else
            pat_nxt_c = {pattern[WIDTH-2:0], 1'b1};
        end
        MODE_COUNT: begin
          if (dir)
            pat_nxt_c = pattern - WIDTH'(1);
          else
            pat_nxt_c = pattern + WIDTH'(1);
        end
      endcase
    end
  end

  // State registers; divider is held at zero while paused
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      step_q  <= 1'b0;
      mode_q  <= MODE_ROTATE;
      bnc_q   <= BNC_UP;
      pattern <= SEED_ONE;
      advance <= 1'b0;
    end else begin
      div_q   <= pause ? '0 : div_q + DIV'(1);
      step_q  <= step;
      mode_q  <= mode;
      bnc_q   <= bnc_nxt_c;
      pattern <= pat_nxt_c;
      advance <= mode_chg_c || adv_evt_c;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with WIDTH=4, DIV=2 (tick every 4 clocks).
module tb_led_pattern_gen;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DIV   = 2;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic             dir;
  logic             pause;
  logic             step;
  logic [WIDTH-1:0] pattern;
  logic             advance;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]       mode;
    logic             dir;
    logic [WIDTH-1:0] pat;
    int               gap;
  } vec_t;

  vec_t vecs[$];

  led_pattern_gen #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .dir     (dir),
    .pause   (pause),
    .step    (step),
    .pattern (pattern),
    .advance (advance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] m, input logic d, input logic [WIDTH-1:0] p, input int g);
    vec_t v;
    v.mode = m;
    v.dir  = d;
    v.pat  = p;
    v.gap  = g;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Clocks until advance is seen (sampled 1ns after each edge); -1 on timeout
  task automatic wait_adv(input int max_cyc, output int gap);
    gap = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk);
      #1;
      if (advance) begin
        gap = n;
        break;
      end
    end
  endtask

  initial begin
    int gap;
    int bad;
    int adv_cnt;

    rst   = 1'b1;
    mode  = 2'd0;
    dir   = 1'b0;
    pause = 1'b0;
    step  = 1'b0;

    // Rotate, bounce, fill and count in sequence; each entry ends on an advance
    vecs.push_back(mk(2'd0, 1'b0, 4'b0010, 4));
    vecs.push_back(mk(2'd0, 1'b0, 4'b0100, 4));
    vecs.push_back(mk(2'd0, 1'b0, 4'b1000, 4));
    vecs.push_back(mk(2'd0, 1'b0, 4'b0001, 4));
    vecs.push_back(mk(2'd1, 1'b0, 4'b0001, 1));
    vecs.push_back(mk(2'd1, 1'b0, 4'b0010, 3));
    vecs.push_back(mk(2'd1, 1'b1, 4'b0100, 4));
    vecs.push_back(mk(2'd1, 1'b0, 4'b1000, 4));
    vecs.push_back(mk(2'd1, 1'b1, 4'b0100, 4));
    vecs.push_back(mk(2'd1, 1'b1, 4'b0010, 4));
    vecs.push_back(mk(2'd1, 1'b0, 4'b0001, 4));
    vecs.push_back(mk(2'd1, 1'b1, 4'b0010, 4));
    vecs.push_back(mk(2'd2, 1'b0, 4'b0000, 1));
    vecs.push_back(mk(2'd2, 1'b0, 4'b0001, 3));
    vecs.push_back(mk(2'd2, 1'b0, 4'b0011, 4));
    vecs.push_back(mk(2'd2, 1'b0, 4'b0111, 4));
    vecs.push_back(mk(2'd2, 1'b0, 4'b1111, 4));
    vecs.push_back(mk(2'd2, 1'b0, 4'b0000, 4));
    vecs.push_back(mk(2'd2, 1'b1, 4'b1000, 4));
    vecs.push_back(mk(2'd2, 1'b1, 4'b1100, 4));
    vecs.push_back(mk(2'd3, 1'b1, 4'b0000, 1));
    vecs.push_back(mk(2'd3, 1'b1, 4'b1111, 3));
    vecs.push_back(mk(2'd3, 1'b1, 4'b1110, 4));
    vecs.push_back(mk(2'd3, 1'b1, 4'b1101, 4));
    vecs.push_back(mk(2'd3, 1'b0, 4'b1110, 4));
    vecs.push_back(mk(2'd3, 1'b0, 4'b1111, 4));
    vecs.push_back(mk(2'd3, 1'b0, 4'b0000, 4));

    #2;
    chk("reset_pattern", int'(pattern), 1);
    chk("reset_advance", int'(advance), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_pattern", int'(pattern), 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      dir  = vecs[i].dir;
      wait_adv(8, gap);
      chk($sformatf("vec%0d_pattern", i), int'(pattern), int'(vecs[i].pat));
      chk($sformatf("vec%0d_gap", i), gap, vecs[i].gap);
    end

    // Paused: nothing moves for 40 clocks
    pause = 1'b1;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (advance || pattern != 4'b0000) bad++;
    end
    chk("pause_hold_bad_cycles", bad, 0);

    // Step held high three clocks gives exactly one advance
    step = 1'b1;
    adv_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (advance) adv_cnt++;
    end
    step = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (advance) adv_cnt++;
    end
    chk("step_adv_count", adv_cnt, 1);
    chk("step_pattern", int'(pattern), 1);

    // Mode change while paused loads the fill seed with one pulse
    mode = 2'd2;
    wait_adv(8, gap);
    chk("pause_mode_gap", gap, 1);
    chk("pause_mode_pattern", int'(pattern), 0);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (advance) bad++;
    end
    chk("pause_after_mode_adv", bad, 0);

    // Resume: divider restarts from zero
    pause = 1'b0;
    wait_adv(8, gap);
    chk("resume_gap", gap, 4);
    chk("resume_pattern", int'(pattern), 1);

    // Count up to 0101, then reset mid-divider
    mode = 2'd3;
    dir  = 1'b0;
    for (int n = 0; n < 6; n++) wait_adv(8, gap);
    chk("pre_reset_pattern", int'(pattern), 5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_pattern", int'(pattern), 1);
    chk("async_reset_advance", int'(advance), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_adv(8, gap);
    chk("post_reset_gap", gap, 1);
    chk("post_reset_pattern", int'(pattern), 0);
    @(posedge clk);
    #1;
    chk("post_reset_adv_low", int'(advance), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 12, number of pattern bits (legal WIDTH >= 2).
REQ-002 SHALL have parameter DIV, default 20, divider width; one tick every 2^DIV clocks (legal DIV >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mode  input  2  0 rotate, 1 bounce, 2 fill, 3 count.
REQ-006 SHALL have port dir  input  1  0 toward MSB / up, 1 toward LSB / down; ignored in bounce.
REQ-007 SHALL have port pause  input  1  stop automatic advance; enables manual stepping.
REQ-008 SHALL have port step  input  1  manual advance request, rising-edge detected.
REQ-009 SHALL have port pattern  output  WIDTH  registered LED pattern.
REQ-010 SHALL have port advance  output  1  registered one-cycle pulse, high in the same cycle a new pattern value is first visible.

Function
REQ-011 SHALL run a DIV-bit divider counter that increments every cycle while pause=0 and is held at 0 every cycle pause=1.
REQ-012 SHALL raise internal tick when pause=0 and the divider equals 2^DIV-1; the divider then wraps to 0.
REQ-013 SHALL register step into step_q every cycle; step_rise = step & !step_q.
REQ-014 SHALL define adv_evt = tick | (pause & step_rise); step_rise while pause=0 is ignored.
REQ-015 SHALL register mode into mode_q every cycle; mode != mode_q is a mode change.
REQ-016 On a mode change SHALL load the new mode's seed (rotate 1, bounce 1 with bounce direction up, fill 0, count 0), pulse advance, and discard any adv_evt in that cycle.
REQ-017 Otherwise, on adv_evt SHALL update pattern per mode and pulse advance; the result is visible one clock after the event cycle.
REQ-018 Rotate: dir=0 gives {p[W-2:0],p[W-1]}; dir=1 gives {p[0],p[W-1:1]}; an all-zero pattern reloads 1.
REQ-019 Bounce: single hot bit moves one position per advance; at bit W-1 moving up it reverses to W-2 and moves down; at bit 0 moving down it reverses to bit 1; period 2W-2 advances.
REQ-020 Bounce: a pattern not exactly one-hot reloads 1 with direction up.
REQ-021 Fill: dir=0 gives {p[W-2:0],1'b1}; dir=1 gives {1'b1,p[W-1:1]}; an all-ones pattern goes to all-zeros; period W+1.
REQ-022 Count: dir=0 increments and dir=1 decrements, modulo 2^W.
REQ-023 A dir change SHALL take effect at the next advance with no reload.
REQ-024 advance SHALL be 0 in every cycle that does not follow an event or mode change.

Reset
REQ-025 While rst=1 SHALL force immediately, regardless of clk: divider 0, pattern 1, bounce direction up, step_q 0, mode_q 0, advance 0.
REQ-026 After rst deasserts with mode != 0 SHALL treat the first edge as a mode change per REQ-016.
REQ-027 After rst deasserts with pause=0, the first tick SHALL occur 2^DIV clocks later.

Verification (WIDTH=4, DIV=2, tick every 4 clocks)
REQ-028 mode=0, dir=0 from reset -> pattern 0001,0010,0100,1000,0001 at 4-clock spacing; advance is one-cycle each step.
REQ-029 mode=1 -> 0001,0010,0100,1000,0100,0010,0001,0010; toggling dir changes nothing.
REQ-030 mode=2, dir=0 -> 0000,0001,0011,0111,1111,0000; dir=1 from 0000 -> 1000,1100.
REQ-031 mode=3, dir=1 from seed -> 1111,1110,1101; dir=0 from 1111 -> 0000 wrap.
REQ-032 pause=1 for 40 clocks -> pattern constant; step held high 3 clocks -> exactly one advance; mode change while paused -> seed loaded with one advance pulse; pause=0 -> next advance 4 clocks later.
REQ-033 rst asserted mid-divider in mode 3 with pattern 0101 -> pattern 0001 and advance 0 before the next clk edge; after release the mode-change seed gives 0000.
